// File: rtl/ring_osc_trim_ctrl_if.sv
// Housekeeping-side control/status bundle for the ring oscillator trim calibrator.
// master = configuration register block, slave = calibration controller.
interface ring_osc_trim_ctrl_if #(
    parameter int CW = 16
);
    logic          enable;
    logic          start;
    logic [CW-1:0] target;
    logic [CW-1:0] tol;
    logic [CW-1:0] meas_count;
    logic          busy;
    logic          locked;
    logic          fail;

    modport master (
        output enable, start, target, tol,
        input  meas_count, busy, locked, fail
    );

    modport slave (
        input  enable, start, target, tol,
        output meas_count, busy, locked, fail
    );
endinterface

// File: rtl/ring_osc_trim_ctrl.sv
// Closed-loop trim calibration for the 13-stage ring oscillator: resets it, counts
// divided-clock edges per window and walks the thermometer trim level until in tolerance.
module ring_osc_trim_ctrl #(
    parameter int WINDOW     = 1024,
    parameter int RST_CYCLES = 16,
    parameter int SETTLE     = 64,
    parameter int INIT_LEVEL = 13,
    parameter int MAX_ITER   = 64,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ring_osc_trim_ctrl_if.slave   cfg,
    input  logic                  osc_div,
    output logic                  osc_reset,
    output logic [25:0]           trim,
    output logic [4:0]            level
);
    localparam int TMAX = (WINDOW > SETTLE) ? ((WINDOW > RST_CYCLES) ? WINDOW : RST_CYCLES)
                                            : ((SETTLE > RST_CYCLES) ? SETTLE : RST_CYCLES);
    localparam int TW = $clog2(TMAX + 1);
    localparam int IW = $clog2(MAX_ITER + 1);

    // Primary bits fill first; secondary bit i only once all 13 primaries are set.
    function automatic logic [25:0] encode(input logic [4:0] l);
        logic [25:0] t;
        t = '0;
        for (int i = 0; i < 13; i++) begin
            t[i]      = (l > 5'(i));
            t[13 + i] = (l > 5'(13 + i));
        end
        return t;
    endfunction

    localparam logic [4:0]  LEVEL_INIT = 5'(INIT_LEVEL);
    localparam logic [25:0] TRIM_INIT  = encode(LEVEL_INIT);

    typedef enum logic [2:0] {
        S_IDLE, S_OSC_RST, S_SETTLE, S_MEASURE, S_COMPARE, S_ADJUST, S_LOCKED, S_FAIL
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [IW-1:0] iter_reg, iter_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] meas_reg, meas_next;
    logic [4:0]    level_reg, level_next;
    logic [25:0]   trim_reg;
    logic          dir_up_reg, dir_up_next;
    logic          osc_reset_reg, osc_reset_next;
    logic          busy_reg, busy_next;
    logic          locked_reg, locked_next;
    logic          fail_reg, fail_next;
    logic [1:0]    sync_reg;
    logic          prev_reg, edge_reg;

    logic          restart;
    logic [CW:0]   lo_wide, hi_wide;
    logic [CW-1:0] lo_bound, hi_bound;
    logic          in_range, too_fast;

    assign restart  = cfg.start & cfg.enable;
    assign lo_wide  = {1'b0, cfg.target} - {1'b0, cfg.tol};
    assign hi_wide  = {1'b0, cfg.target} + {1'b0, cfg.tol};
    assign lo_bound = lo_wide[CW] ? '0 : lo_wide[CW-1:0];
    assign hi_bound = hi_wide[CW] ? {CW{1'b1}} : hi_wide[CW-1:0];
    assign in_range = (cnt_reg >= lo_bound) && (cnt_reg <= hi_bound);
    assign too_fast = (cnt_reg > hi_bound);

    // osc_div is asynchronous: two-flop synchronizer, then a registered edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], osc_div};
            prev_reg <= sync_reg[1];
            edge_reg <= sync_reg[1] & ~prev_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!cfg.enable) begin
            state_next = S_IDLE;
        end else if (cfg.start) begin
            state_next = S_OSC_RST;
        end else begin
            case (state_reg)
                S_OSC_RST: if (timer_reg == '0) state_next = S_SETTLE;
                S_SETTLE:  if (timer_reg == '0) state_next = S_MEASURE;
                S_MEASURE: if (timer_reg == '0) state_next = S_COMPARE;
                S_COMPARE: begin
                    if (in_range)                     state_next = S_LOCKED;
                    else if (iter_reg == IW'(MAX_ITER)) state_next = S_FAIL;
                    else if (too_fast)                state_next = (level_reg == 5'd26) ? S_FAIL : S_ADJUST;
                    else                              state_next = (level_reg == 5'd0)  ? S_FAIL : S_ADJUST;
                end
                S_ADJUST:  state_next = S_SETTLE;
                default:   state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        osc_reset_next = (state_next == S_IDLE) || (state_next == S_OSC_RST);
        busy_next      = (state_next == S_OSC_RST) || (state_next == S_SETTLE) ||
                         (state_next == S_MEASURE) || (state_next == S_COMPARE) ||
                         (state_next == S_ADJUST);
        locked_next    = restart ? 1'b0 : ((state_next == S_LOCKED) ? 1'b1 : locked_reg);
        fail_next      = restart ? 1'b0 : ((state_next == S_FAIL)   ? 1'b1 : fail_reg);
        dir_up_next    = (state_reg == S_COMPARE) ? too_fast : dir_up_reg;
        meas_next      = (state_reg == S_COMPARE) ? cnt_reg : meas_reg;

        level_next = level_reg;
        iter_next  = iter_reg;
        if (restart) begin
            level_next = LEVEL_INIT;
            iter_next  = '0;
        end else if (state_reg == S_ADJUST && state_next == S_SETTLE) begin
            level_next = dir_up_reg ? level_reg + 5'd1 : level_reg - 5'd1;
            iter_next  = iter_reg + 1'b1;
        end

        // Each timed state is loaded with its length minus one on entry.
        timer_next = timer_reg;
        if (state_next != state_reg || restart) begin
            case (state_next)
                S_OSC_RST: timer_next = TW'(RST_CYCLES - 1);
                S_SETTLE:  timer_next = TW'(SETTLE - 1);
                S_MEASURE: timer_next = TW'(WINDOW - 1);
                default:   timer_next = '0;
            endcase
        end else if (timer_reg != '0) begin
            timer_next = timer_reg - 1'b1;
        end

        cnt_next = cnt_reg;
        if (state_next == S_MEASURE && state_reg != S_MEASURE)
            cnt_next = '0;
        else if (state_reg == S_MEASURE && edge_reg && cnt_reg != {CW{1'b1}})
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg     <= '0;
            iter_reg      <= '0;
            cnt_reg       <= '0;
            meas_reg      <= '0;
            level_reg     <= LEVEL_INIT;
            trim_reg      <= TRIM_INIT;
            dir_up_reg    <= 1'b0;
            osc_reset_reg <= 1'b1;
            busy_reg      <= 1'b0;
            locked_reg    <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            timer_reg     <= timer_next;
            iter_reg      <= iter_next;
            cnt_reg       <= cnt_next;
            meas_reg      <= meas_next;
            level_reg     <= level_next;
            trim_reg      <= encode(level_reg);
            dir_up_reg    <= dir_up_next;
            osc_reset_reg <= osc_reset_next;
            busy_reg      <= busy_next;
            locked_reg    <= locked_next;
            fail_reg      <= fail_next;
        end
    end

    assign osc_reset      = osc_reset_reg;
    assign trim           = trim_reg;
    assign level          = level_reg;
    assign cfg.meas_count = meas_reg;
    assign cfg.busy       = busy_reg;
    assign cfg.locked     = locked_reg;
    assign cfg.fail       = fail_reg;
endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// Directed bench for ring_osc_trim_ctrl with a behavioural oscillator whose edge
// count per window is 500 - 15*level (a quarter-scale of 2000 - 60*level).
module tb_ring_osc_trim_ctrl;
    localparam int CW       = 16;
    localparam int WINDOW   = 1024;
    localparam int RSTC     = 4;
    localparam int SETTLE_C = 16;
    // start-cycle to first result, and cost of each further window
    localparam int FIRST    = RSTC + SETTLE_C + WINDOW + 2;
    localparam int STEP     = 2 + SETTLE_C + WINDOW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        osc_div = 1'b0;
    logic        osc_reset;
    logic [25:0] trim;
    logic [4:0]  level;

    int total = 0;
    int bad   = 0;
    int cyc;
    int ph = 0;
    bit osc_en = 1'b1;

    ring_osc_trim_ctrl_if #(.CW(CW)) cfg ();

    ring_osc_trim_ctrl #(
        .WINDOW(WINDOW), .RST_CYCLES(RSTC), .SETTLE(SETTLE_C),
        .INIT_LEVEL(13), .MAX_ITER(64), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .cfg(cfg.slave), .osc_div(osc_div),
        .osc_reset(osc_reset), .trim(trim), .level(level)
    );

    always #5 clk = ~clk;

    // Pattern repeats every WINDOW cycles, so any full window sees exactly n edges.
    always @(negedge clk) begin
        int n;
        n = 500 - 15 * $countones(trim);
        osc_div = osc_en && (ph[0] == 1'b0) && ((ph / 2) < n);
        ph = (ph + 1) % WINDOW;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(inout int c);
        do begin
            @(negedge clk);
            c++;
        end while (!(cfg.locked || cfg.fail) && c < 20000);
    endtask

    task automatic run_cal(input logic [15:0] tgt, input logic [15:0] tl, output int c);
        @(negedge clk);
        cfg.target = tgt;
        cfg.tol    = tl;
        cfg.enable = 1'b1;
        cfg.start  = 1'b1;
        @(posedge clk);
        #1 cfg.start = 1'b0;
        c = 0;
        wait_done(c);
        $display("cal target=%0d tol=%0d: cycles=%0d level=%0d meas=%0d locked=%0b fail=%0b",
                 tgt, tl, c, level, cfg.meas_count, cfg.locked, cfg.fail);
    endtask

    initial begin
        cfg.enable = 1'b0;
        cfg.start  = 1'b0;
        cfg.target = '0;
        cfg.tol    = '0;

        repeat (3) @(negedge clk);
        chk("rst_osc_reset", 32'(osc_reset), 32'd1);
        chk("rst_level", 32'(level), 32'd13);
        chk("rst_trim", 32'(trim), 32'h0001FFF);
        chk("rst_meas", 32'(cfg.meas_count), 32'd0);
        chk("rst_busy", 32'(cfg.busy), 32'd0);
        chk("rst_locked", 32'(cfg.locked), 32'd0);
        chk("rst_fail", 32'(cfg.fail), 32'd0);
        reset = 1'b0;
        $display("reset released");

        // Already on target at the initial level.
        run_cal(16'd305, 16'd5, cyc);
        chk("lock1_cycles", 32'(cyc), 32'(FIRST));
        chk("lock1_locked", 32'(cfg.locked), 32'd1);
        chk("lock1_fail", 32'(cfg.fail), 32'd0);
        chk("lock1_level", 32'(level), 32'd13);
        chk("lock1_trim", 32'(trim), 32'h0001FFF);
        chk("lock1_meas", 32'(cfg.meas_count), 32'd305);
        chk("lock1_busy", 32'(cfg.busy), 32'd0);
        chk("lock1_osc_reset", 32'(osc_reset), 32'd0);

        // Too fast: level walks 13 -> 20 over 8 windows.
        run_cal(16'd200, 16'd2, cyc);
        chk("lock8_cycles", 32'(cyc), 32'(FIRST + 7 * STEP));
        chk("lock8_locked", 32'(cfg.locked), 32'd1);
        chk("lock8_level", 32'(level), 32'd20);
        chk("lock8_trim", 32'(trim), 32'h00FFFFF);
        chk("lock8_meas", 32'(cfg.meas_count), 32'd200);

        // Unreachable, too slow: saturates at level 0.
        run_cal(16'd750, 16'd5, cyc);
        chk("slow_cycles", 32'(cyc), 32'(FIRST + 13 * STEP));
        chk("slow_fail", 32'(cfg.fail), 32'd1);
        chk("slow_locked", 32'(cfg.locked), 32'd0);
        chk("slow_level", 32'(level), 32'd0);
        chk("slow_trim", 32'(trim), 32'h0000000);
        chk("slow_meas", 32'(cfg.meas_count), 32'd500);

        // Unreachable, too fast: saturates at level 26.
        run_cal(16'd25, 16'd5, cyc);
        chk("fast_cycles", 32'(cyc), 32'(FIRST + 13 * STEP));
        chk("fast_fail", 32'(cfg.fail), 32'd1);
        chk("fast_level", 32'(level), 32'd26);
        chk("fast_trim", 32'(trim), 32'h3FFFFFF);
        chk("fast_meas", 32'(cfg.meas_count), 32'd110);

        // start with enable low is ignored; status holds.
        @(negedge clk);
        cfg.enable = 1'b0;
        cfg.start  = 1'b1;
        @(posedge clk);
        #1 cfg.start = 1'b0;
        @(negedge clk);
        chk("dis_busy", 32'(cfg.busy), 32'd0);
        chk("dis_osc_reset", 32'(osc_reset), 32'd1);
        chk("dis_fail_hold", 32'(cfg.fail), 32'd1);
        chk("dis_level_hold", 32'(level), 32'd26);
        $display("start with enable low: busy=%0b fail=%0b", cfg.busy, cfg.fail);

        // Drop enable during the second measurement window (level 14).
        @(negedge clk);
        cfg.target = 16'd200;
        cfg.tol    = 16'd2;
        cfg.enable = 1'b1;
        cfg.start  = 1'b1;
        @(posedge clk);
        #1 cfg.start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (level != 5'd14 && cyc < 5000);
        chk("abort_reach_l14", 32'(level), 32'd14);
        repeat (200) @(negedge clk);
        cfg.enable = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(cfg.busy), 32'd0);
        chk("abort_osc_reset", 32'(osc_reset), 32'd1);
        chk("abort_level", 32'(level), 32'd14);
        chk("abort_locked", 32'(cfg.locked), 32'd0);
        $display("enable dropped: level=%0d busy=%0b", level, cfg.busy);

        cfg.target = 16'd305;
        cfg.tol    = 16'd5;
        cfg.enable = 1'b1;
        cfg.start  = 1'b1;
        @(posedge clk);
        #1 cfg.start = 1'b0;
        cyc = 0;
        @(negedge clk);
        cyc++;
        chk("restart_level", 32'(level), 32'd13);
        chk("restart_busy", 32'(cfg.busy), 32'd1);
        chk("restart_osc_reset", 32'(osc_reset), 32'd1);
        wait_done(cyc);
        chk("restart_cycles", 32'(cyc), 32'(FIRST));
        chk("restart_locked", 32'(cfg.locked), 32'd1);
        $display("restart: cycles=%0d level=%0d locked=%0b", cyc, level, cfg.locked);

        // Assert reset while in ADJUST after the first window.
        @(negedge clk);
        cfg.target = 16'd200;
        cfg.tol    = 16'd2;
        cfg.start  = 1'b1;
        @(posedge clk);
        #1 cfg.start = 1'b0;
        for (int i = 0; i < FIRST; i++) @(negedge clk);
        chk("adj_busy_before", 32'(cfg.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_osc_reset", 32'(osc_reset), 32'd1);
        chk("arst_level", 32'(level), 32'd13);
        chk("arst_trim", 32'(trim), 32'h0001FFF);
        chk("arst_meas", 32'(cfg.meas_count), 32'd0);
        chk("arst_busy", 32'(cfg.busy), 32'd0);
        chk("arst_locked", 32'(cfg.locked), 32'd0);
        chk("arst_fail", 32'(cfg.fail), 32'd0);
        $display("async reset in ADJUST: level=%0d meas=%0d", level, cfg.meas_count);
        @(negedge clk);
        reset  = 1'b0;
        osc_en = 1'b0;

        // Dead oscillator: every window reads 0, level walks down to 0.
        run_cal(16'd305, 16'd5, cyc);
        chk("dead_cycles", 32'(cyc), 32'(FIRST + 13 * STEP));
        chk("dead_fail", 32'(cfg.fail), 32'd1);
        chk("dead_level", 32'(level), 32'd0);
        chk("dead_trim", 32'(trim), 32'h0000000);
        chk("dead_meas", 32'(cfg.meas_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ring_osc_trim_ctrl.md
# ring_osc_trim_ctrl

Closed-loop trim calibration controller for the 13-stage, 26-trim-bit ring oscillator. It resets and starts the oscillator, then measures the oscillator against the reference clock. It steps the trim code one delay unit at a time until the measured frequency is within tolerance of a programmed target. It sits in the clocking block between the housekeeping configuration registers and the oscillator's `reset`/`trim` inputs.

## Interface
Parameters:
- `WINDOW`, 1024: measurement window length, in `clk` cycles.
- `RST_CYCLES`, 16: `clk` cycles `osc_reset` is held high before each start.
- `SETTLE`, 64: `clk` cycles waited after a trim change or start before measuring.
- `INIT_LEVEL`, 13: trim level loaded at reset and at each calibration start (0..26).
- `MAX_ITER`, 64: maximum number of adjust steps before `fail`.
- `CW`, 16: width of the edge counter, target and tolerance.

Ports:
- `clk` in 1: reference clock; the only clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: level; high runs calibration, low aborts to IDLE.
- `start` in 1: one-cycle pulse; begins or restarts calibration when `enable`=1.
- `target` in CW: expected `osc_div` rising edges per window.
- `tol` in CW: allowed deviation (inclusive).
- `osc_div` in 1: divided oscillator output, asynchronous to `clk`.
- `osc_reset` out 1: drives the oscillator `reset`.
- `trim` out 26: drives the oscillator `trim`.
- `level` out 5: current trim level, 0..26.
- `meas_count` out CW: last completed window count.
- `busy` out 1: a calibration is in progress.
- `locked` out 1: the last calibration converged.
- `fail` out 1: the last calibration saturated or hit `MAX_ITER`.

## Operation
- Level to trim encoding (thermometer):
  - `trim[i]` = (i < min(L,13)) for i = 0..12.
  - `trim[13+i]` = (i < L−13) for i = 0..12, when L > 13; otherwise these bits are 0.
  - Consequence: primary bits always fill before secondary bits, and a secondary bit is never set without its stage's primary bit.
  - `trim` is registered from `level`. Any level change alters exactly one trim bit.
- `osc_div` path: two-flop synchronizer, then a registered rising-edge detector. An edge contributes to the count 3 `clk` cycles after it occurs.
- FSM states: IDLE, OSC_RST, SETTLE, MEASURE, COMPARE, ADJUST, LOCKED, FAIL.
  - IDLE: `osc_reset`=1. On `start`&`enable`: level←INIT_LEVEL, iteration counter←0, locked←0, fail←0, then go to OSC_RST.
  - OSC_RST: `osc_reset`=1 for RST_CYCLES cycles, then SETTLE.
  - SETTLE: `osc_reset`=0; wait SETTLE cycles, then MEASURE.
  - MEASURE: clear the edge counter on entry, count edges for exactly WINDOW cycles, then COMPARE. The counter saturates at 2^CW−1.
  - COMPARE (1 cycle): `meas_count`←count, then apply the first matching rule:
    - `target−tol` ≤ count ≤ `target+tol` → LOCKED. Compute the bounds at CW+1 bits, clamping the low bound at 0 and the high bound at 2^CW−1.
    - count > high bound → the oscillator is too fast, so step the level up. If level=26 → FAIL.
    - count < low bound → the oscillator is too slow, so step the level down. If level=0 → FAIL.
    - iteration counter = MAX_ITER → FAIL. This check has priority over an adjust.
  - ADJUST (1 cycle): level ±1, iteration counter +1, then SETTLE. The oscillator is not reset on trim changes.
  - LOCKED: `locked`=1, `busy`=0, `osc_reset`=0; trim is held.
  - FAIL: `fail`=1, `busy`=0, `osc_reset`=0; the last trim is held.
- `start` in any state with `enable`=1 restarts from the IDLE-exit actions.
- `enable`=0 in any state → IDLE next cycle. On that transition `locked`, `fail` and `level` hold their values and `osc_reset`=1.
- `start` while `enable`=0 is ignored.

## Timing
- Reset values:
  - `osc_reset`=1, `level`=INIT_LEVEL, `trim`=encode(INIT_LEVEL).
  - `meas_count`=0, `busy`=0, `locked`=0, `fail`=0.
  - FSM in IDLE.
- `busy`=1 in OSC_RST, SETTLE, MEASURE, COMPARE and ADJUST.
- All outputs are registered.
- Cycle counts:
  - `start` to `osc_reset` falling: RST_CYCLES+1 cycles.
  - First COMPARE: 1 + RST_CYCLES + SETTLE + WINDOW cycles after `start`.
  - Each extra iteration: 2 + SETTLE + WINDOW cycles.
- `trim` changes 1 cycle after `level` changes.

## Test plan
- Behavioral oscillator model with edges per window = 2000 − 60·L, `target`=1220, `tol`=20.
  - From INIT 13: 1220 at L=13 → LOCKED after one window; `level`=13, `trim`=0x0001FFF, `meas_count`=1220.
- Same model, `target`=800, `tol`=10.
  - Level steps 13→20; `locked`=1; `trim`=0x00FFFFF; 8 windows completed.
- `target`=3000 (unreachable, too slow): level steps down to 0 → `fail`=1, `trim`=0, `locked`=0.
- `target`=100 (unreachable, too fast): level reaches 26 → `fail`=1, `trim`=0x3FFFFFF.
- `enable` dropped mid-MEASURE:
  - Next cycle: IDLE, `osc_reset`=1, `busy`=0, `level` unchanged.
  - Re-asserting `enable` with `start` restarts from INIT_LEVEL.
- `reset` asserted mid-ADJUST: all outputs take their reset values immediately (asynchronously). `osc_div` held static → count 0 → level decrements to 0, then `fail`.
